// File: rtl/axi_lite_arbiter_pkg.sv
// Shared definitions for the two-master AXI-Lite arbiter: FSM encoding,
// grant owner and AXI response codes.
package axi_lite_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RD0  = 2'd1;
  localparam state_t ST_RD1  = 2'd2;
  localparam state_t ST_WR1  = 2'd3;

  typedef enum logic {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } grant_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Owner recorded as last_grant when a transaction in state st completes.
  function automatic grant_e owner_of(state_t st);
    return (st == ST_RD0) ? GNT_M0 : GNT_M1;
  endfunction

endpackage

// File: rtl/axi_lite_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the
// master that was not granted last (last = 1 means M1 was granted last).
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Arbitrates the IFU (M0, read-only) and LSU (M1, read/write) AXI-Lite masters
// onto one memory slave port, one whole transaction at a time.
module axi_lite_arbiter
  import axi_lite_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_W-1:0]     m0_araddr,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,

  input  logic [ADDR_W-1:0]     m1_araddr,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  input  logic [ADDR_W-1:0]     m1_awaddr,
  input  logic                  m1_awvalid,
  output logic                  m1_awready,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  input  logic                  m1_wvalid,
  output logic                  m1_wready,
  output logic [1:0]            m1_bresp,
  output logic                  m1_bvalid,
  input  logic                  m1_bready,

  output logic [ADDR_W-1:0]     s_araddr,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_W-1:0]     s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  output logic [ADDR_W-1:0]     s_awaddr,
  output logic                  s_awvalid,
  input  logic                  s_awready,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [DATA_W/8-1:0]   s_wstrb,
  output logic                  s_wvalid,
  input  logic                  s_wready,
  input  logic [1:0]            s_bresp,
  input  logic                  s_bvalid,
  output logic                  s_bready,

  output logic                  timeout_err
);

  localparam int                CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TMO_CNT = CNT_W'(TIMEOUT);

  state_t                r_state;
  grant_e                r_last;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W/8-1:0]   r_wstrb;
  logic                  r_ar_done;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic [CNT_W-1:0]      r_busy;
  logic                  r_timeout;

  logic [1:0]            w_req;
  logic [1:0]            w_gnt;
  logic                  w_last_m1;
  logic                  w_txn_end;

  assign w_req     = {m1_arvalid | (m1_awvalid & m1_wvalid), m0_arvalid};
  assign w_last_m1 = (r_last == GNT_M1);

  rr_arb2 u_rr_arb2 (
    .req  (w_req),
    .last (w_last_m1),
    .gnt  (w_gnt)
  );

  // Slave-facing payload always comes from the holding registers.
  assign s_araddr    = r_addr;
  assign s_awaddr    = r_addr;
  assign s_wdata     = r_wdata;
  assign s_wstrb     = r_wstrb;
  assign m0_rdata    = s_rdata;
  assign m0_rresp    = s_rresp;
  assign m1_rdata    = s_rdata;
  assign m1_rresp    = s_rresp;
  assign m1_bresp    = s_bresp;
  assign timeout_err = r_timeout;

  // A done flag keeps each address/data channel to a single beat per grant.
  always_comb begin
    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awvalid  = 1'b0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    case (r_state)
      ST_RD0: begin
        s_arvalid  = m0_arvalid & ~r_ar_done;
        m0_arready = s_arready & ~r_ar_done;
        m0_rvalid  = s_rvalid;
        s_rready   = m0_rready;
      end
      ST_RD1: begin
        s_arvalid  = m1_arvalid & ~r_ar_done;
        m1_arready = s_arready & ~r_ar_done;
        m1_rvalid  = s_rvalid;
        s_rready   = m1_rready;
      end
      ST_WR1: begin
        s_awvalid  = m1_awvalid & ~r_aw_done;
        m1_awready = s_awready & ~r_aw_done;
        s_wvalid   = m1_wvalid & ~r_w_done;
        m1_wready  = s_wready & ~r_w_done;
        m1_bvalid  = s_bvalid;
        s_bready   = m1_bready;
      end
      default: ;
    endcase
  end

  // s_rready / s_bready are only nonzero in the matching state.
  assign w_txn_end = (s_rvalid & s_rready) | (s_bvalid & s_bready);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_last    <= GNT_M1;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_ar_done <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt[0]) begin
            r_state <= ST_RD0;
            r_addr  <= m0_araddr;
          end else if (w_gnt[1] && m1_arvalid) begin
            r_state <= ST_RD1;
            r_addr  <= m1_araddr;
          end else if (w_gnt[1]) begin
            r_state <= ST_WR1;
            r_addr  <= m1_awaddr;
            r_wdata <= m1_wdata;
            r_wstrb <= m1_wstrb;
          end
        end
        default: begin
          if (s_arvalid && s_arready) r_ar_done <= 1'b1;
          if (s_awvalid && s_awready) r_aw_done <= 1'b1;
          if (s_wvalid && s_wready)   r_w_done  <= 1'b1;
          if (w_txn_end) begin
            r_state   <= ST_IDLE;
            r_last    <= owner_of(r_state);
            r_ar_done <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end
      endcase
    end
  end

  // Watchdog only observes; it never forces the FSM out of a grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == ST_IDLE || w_txn_end) begin
        r_busy <= '0;
      end else if (r_busy != TMO_CNT) begin
        r_busy <= r_busy + 1'b1;
      end
      if (r_busy == TMO_CNT) r_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Scoreboard bench for axi_lite_arbiter: directed master traffic against a
// small memory slave model; monitors pop expected responses per channel.
`timescale 1ns/1ps
module tb_axi_lite_arbiter;
  import axi_lite_arbiter_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 3000;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } slv_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] m0_araddr, m1_araddr, m1_awaddr, s_araddr, s_awaddr;
  logic          m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [DW-1:0] m0_rdata, m1_rdata, m1_wdata, s_rdata, s_wdata;
  logic [1:0]    m0_rresp, m1_rresp, m1_bresp, s_rresp, s_bresp;
  logic          m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic          m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic [3:0]    m1_wstrb, s_wstrb;
  logic          s_arvalid, s_arready, s_rvalid, s_rready;
  logic          s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic          timeout_err;

  axi_lite_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(1024)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .timeout_err(timeout_err)
  );

  int n_pass    = 0;
  int n_chk     = 0;
  int n_overlap = 0;
  int rdelay    = 1;

  logic [33:0] exp_m0r[$];
  logic [33:0] exp_m1r[$];
  logic [1:0]  exp_m1b[$];
  slv_t        exp_slv[$];

  wire [11:0] w_act = {m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready,
                       m1_bvalid, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready};

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // Memory slave model: reads return mem[addr[9:2]], 0x...FFC answers SLVERR.
  logic [31:0] mem [0:255];
  logic        sl_rpend, sl_bpend;
  int          sl_rcnt;
  logic [31:0] sl_rdat;
  logic [1:0]  sl_rresp;

  assign s_arready = !sl_rpend;
  assign s_rvalid  = sl_rpend && (sl_rcnt == 0);
  assign s_rdata   = s_rvalid ? sl_rdat : 32'h0;
  assign s_rresp   = sl_rresp;
  assign s_awready = s_awvalid && s_wvalid && !sl_bpend;
  assign s_wready  = s_awready;
  assign s_bvalid  = sl_bpend;
  assign s_bresp   = RESP_OKAY;

  always @(posedge clk) begin
    if (!rst) begin
      sl_rpend <= 1'b0;
      sl_bpend <= 1'b0;
      sl_rcnt  <= 0;
      sl_rdat  <= 32'h0;
      sl_rresp <= RESP_OKAY;
      for (int i = 0; i < 256; i++) mem[i] <= {24'hA00000, 8'(i)};
      mem[0]     <= 32'h0000_0413;
      mem[8'h40] <= 32'h1111_2222;
      mem[8'hFF] <= 32'hBAD0_0BAD;
    end else begin
      if (s_arvalid && s_arready) begin
        sl_rpend <= 1'b1;
        sl_rcnt  <= rdelay - 1;
        sl_rdat  <= mem[s_araddr[9:2]];
        sl_rresp <= (s_araddr[11:0] == 12'hFFC) ? RESP_SLVERR : RESP_OKAY;
      end else if (sl_rpend && sl_rcnt > 0) begin
        sl_rcnt <= sl_rcnt - 1;
      end
      if (s_rvalid && s_rready) sl_rpend <= 1'b0;
      if (s_awvalid && s_awready) begin
        for (int b = 0; b < 4; b++)
          if (s_wstrb[b]) mem[s_awaddr[9:2]][8*b +: 8] <= s_wdata[8*b +: 8];
        sl_bpend <= 1'b1;
      end
      if (s_bvalid && s_bready) sl_bpend <= 1'b0;
    end
  end

  task automatic slv_check(input slv_t act);
    if (exp_slv.size() == 0) chk("slv_unexpected", 80'(exp_slv.size()), 80'(1));
    else chk("slv_txn", 80'(act), 80'(exp_slv.pop_front()));
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (m0_rvalid && m0_rready) begin
        if (exp_m0r.size() == 0) chk("m0_r_unexpected", 80'(exp_m0r.size()), 80'(1));
        else chk("m0_r", 80'({m0_rresp, m0_rdata}), 80'(exp_m0r.pop_front()));
      end
      if (m1_rvalid && m1_rready) begin
        if (exp_m1r.size() == 0) chk("m1_r_unexpected", 80'(exp_m1r.size()), 80'(1));
        else chk("m1_r", 80'({m1_rresp, m1_rdata}), 80'(exp_m1r.pop_front()));
      end
      if (m1_bvalid && m1_bready) begin
        if (exp_m1b.size() == 0) chk("m1_b_unexpected", 80'(exp_m1b.size()), 80'(1));
        else chk("m1_b", 80'(m1_bresp), 80'(exp_m1b.pop_front()));
      end
      if (s_arvalid && s_arready) slv_check({1'b0, s_araddr, 32'h0, 4'h0});
      if (s_awvalid && s_awready) slv_check({1'b1, s_awaddr, s_wdata, s_wstrb});
      if (s_bready && (s_arvalid || s_rready || m0_arready || m1_arready || m0_rvalid || m1_rvalid))
        n_overlap++;
      if (s_rready && (s_awvalid || s_wvalid || m1_awready || m1_wready || m1_bvalid))
        n_overlap++;
    end
  end

  task automatic m0_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    logic hs;
    int   k;
    exp_m0r.push_back({r, d});
    m0_araddr = a; m0_arvalid = 1'b1; k = 0;
    while (m0_arvalid && k < LIM) begin
      @(negedge clk); hs = m0_arready;
      @(posedge clk); #1;
      if (hs) begin m0_arvalid = 1'b0; m0_araddr = '1; end
      k++;
    end
    chk("m0_ar_handshake", 80'(m0_arvalid), 80'(0));
  endtask

  task automatic m1_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    logic hs;
    int   k;
    exp_m1r.push_back({r, d});
    m1_araddr = a; m1_arvalid = 1'b1; k = 0;
    while (m1_arvalid && k < LIM) begin
      @(negedge clk); hs = m1_arready;
      @(posedge clk); #1;
      if (hs) begin m1_arvalid = 1'b0; m1_araddr = '1; end
      k++;
    end
    chk("m1_ar_handshake", 80'(m1_arvalid), 80'(0));
  endtask

  task automatic m1_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic ha, hw;
    int   k;
    exp_m1b.push_back(RESP_OKAY);
    m1_awaddr = a; m1_awvalid = 1'b1;
    m1_wdata = d; m1_wstrb = s; m1_wvalid = 1'b1; k = 0;
    while ((m1_awvalid || m1_wvalid) && k < LIM) begin
      @(negedge clk); ha = m1_awready; hw = m1_wready;
      @(posedge clk); #1;
      if (ha) begin m1_awvalid = 1'b0; m1_awaddr = '1; end
      if (hw) begin m1_wvalid = 1'b0; m1_wdata = '1; m1_wstrb = '0; end
      k++;
    end
    chk("m1_aw_w_handshake", 80'({m1_awvalid, m1_wvalid}), 80'(0));
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_m0r.size() + exp_m1r.size() + exp_m1b.size() + exp_slv.size()) != 0 && k < LIM) begin
      @(negedge clk); k++;
    end
    chk("drain_pending", 80'(exp_m0r.size() + exp_m1r.size() + exp_m1b.size() + exp_slv.size()), 80'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, required finish before 200us");
    $fatal(1, "bench stalled");
  end

  initial begin
    logic hs;
    int   k;
    m0_araddr = '0; m0_arvalid = 1'b1; m0_rready = 1'b1;
    m1_araddr = '0; m1_arvalid = 1'b0; m1_rready = 1'b1;
    m1_awaddr = '0; m1_awvalid = 1'b0; m1_wdata = '0; m1_wstrb = '0;
    m1_wvalid = 1'b0; m1_bready = 1'b1;

    // Reset with a request pending: nothing may be granted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 80'(w_act), 80'(0));
    chk("reset_timeout", 80'(timeout_err), 80'(0));
    @(posedge clk); #1;
    m0_arvalid = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk); #1;

    // First tie after reset: M0 first, then M1.
    exp_slv.push_back({1'b0, 32'h8000_0004, 32'h0, 4'h0});
    exp_slv.push_back({1'b0, 32'h8000_0008, 32'h0, 4'h0});
    fork
      m0_read(32'h8000_0004, 32'hA000_0001, RESP_OKAY);
      m1_read(32'h8000_0008, 32'hA000_0002, RESP_OKAY);
    join
    drain();

    // Single M0 read: one-cycle grant latency, back to IDLE after R.
    exp_slv.push_back({1'b0, 32'h8000_0000, 32'h0, 4'h0});
    exp_m0r.push_back({RESP_OKAY, 32'h0000_0413});
    m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1;
    @(negedge clk); chk("ar_before_grant", 80'(s_arvalid), 80'(0));
    @(negedge clk); chk("ar_after_grant", 80'(s_arvalid), 80'(1));
    @(posedge clk); #1; m0_arvalid = 1'b0; m0_araddr = '1;
    @(negedge clk); chk("r_cycle", 80'({m0_rvalid, s_arvalid}), 80'(2'b10));
    @(negedge clk); chk("idle_after_r", 80'(w_act), 80'(0));
    drain();

    // Tie with M0 granted last: M1 first; M0 read also checks SLVERR passthrough.
    exp_slv.push_back({1'b0, 32'h8000_000C, 32'h0, 4'h0});
    exp_slv.push_back({1'b0, 32'h8000_0FFC, 32'h0, 4'h0});
    fork
      m0_read(32'h8000_0FFC, 32'hBAD0_0BAD, RESP_SLVERR);
      m1_read(32'h8000_000C, 32'hA000_0003, RESP_OKAY);
    join
    drain();

    // M1 write granted, M0 read raised during WR1 must wait.
    exp_slv.push_back({1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 4'b0011});
    exp_slv.push_back({1'b0, 32'h8000_0010, 32'h0, 4'h0});
    fork
      m1_write(32'h8000_0100, 32'hDEAD_BEEF, 4'b0011);
      begin
        @(posedge clk); #1;
        m0_read(32'h8000_0010, 32'hA000_0004, RESP_OKAY);
      end
    join
    drain();
    exp_slv.push_back({1'b0, 32'h8000_0100, 32'h0, 4'h0});
    m1_read(32'h8000_0100, 32'h1111_BEEF, RESP_OKAY);
    drain();

    // M1 read and write together: read first, then write.
    exp_slv.push_back({1'b0, 32'h8000_0014, 32'h0, 4'h0});
    exp_slv.push_back({1'b1, 32'h8000_0018, 32'h1234_5678, 4'hF});
    fork
      m1_read(32'h8000_0014, 32'hA000_0005, RESP_OKAY);
      m1_write(32'h8000_0018, 32'h1234_5678, 4'hF);
    join
    drain();
    exp_slv.push_back({1'b0, 32'h8000_0018, 32'h0, 4'h0});
    m0_read(32'h8000_0018, 32'h1234_5678, RESP_OKAY);
    drain();

    // Slow slave: watchdog flags but the read still completes.
    rdelay = 1100;
    exp_slv.push_back({1'b0, 32'h8000_001C, 32'h0, 4'h0});
    m0_read(32'h8000_001C, 32'hA000_0007, RESP_OKAY);
    repeat (900) @(posedge clk);
    @(negedge clk); chk("timeout_early", 80'(timeout_err), 80'(0));
    @(posedge clk); #1;
    drain();
    chk("timeout_set", 80'(timeout_err), 80'(1));
    rdelay = 5;

    // Reset in the middle of an M1 read.
    exp_slv.push_back({1'b0, 32'h8000_0020, 32'h0, 4'h0});
    m1_araddr = 32'h8000_0020; m1_arvalid = 1'b1; k = 0;
    while (m1_arvalid && k < LIM) begin
      @(negedge clk); hs = m1_arready;
      @(posedge clk); #1;
      if (hs) begin m1_arvalid = 1'b0; m1_araddr = '1; end
      k++;
    end
    @(negedge clk); chk("rd1_active", 80'({s_rready, s_rvalid}), 80'(2'b10));
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    rdelay = 1;
    @(negedge clk);
    chk("reset_mid_outputs", 80'(w_act), 80'(0));
    chk("reset_mid_timeout", 80'(timeout_err), 80'(0));
    @(negedge clk); chk("reset_mid_still_idle", 80'(w_act), 80'(0));
    @(posedge clk); #1;
    drain();
    exp_slv.push_back({1'b0, 32'h8000_0000, 32'h0, 4'h0});
    m1_read(32'h8000_0000, 32'h0000_0413, RESP_OKAY);
    drain();

    chk("slave_overlap_cycles", 80'(n_overlap), 80'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
